issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_pkg.sv | 21 ++
 rtl/sb_regvec.sv | 47 ++++
 rtl/issue_scoreboard.sv | 171 +++++++++++++++++
 tb/tb_issue_scoreboard.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared parameters for the issue scoreboard: outstanding-op limit and the
// one-hot decoded instruction encodings carried through the issue stage.
package issue_scoreboard_pkg;

    localparam int MAX_OUTST_DEFAULT = 4;
    localparam int INST_W            = 64;

    localparam logic [INST_W-1:0] INST_NONE = 64'h0000_0000_0000_0000;
    localparam logic [INST_W-1:0] INST_ADD  = 64'h0000_0000_0000_0001;
    localparam logic [INST_W-1:0] INST_SUB  = 64'h0000_0000_0000_0002;
    localparam logic [INST_W-1:0] INST_MUL  = 64'h0000_0000_0000_0004;
    localparam logic [INST_W-1:0] INST_DIV  = 64'h0000_0000_0000_0008;
    localparam logic [INST_W-1:0] INST_FLW  = 64'h0000_0000_0000_0010;
    localparam logic [INST_W-1:0] INST_FSW  = 64'h0000_0000_0000_0020;

    // Pick the busy bit from the register file named by the operand's FP flag.
    function automatic logic busy_sel(input logic fp, input logic int_bit, input logic fp_bit);
        return fp ? fp_bit : int_bit;
    endfunction

endpackage

// File: rtl/sb_regvec.sv
// 32-entry busy vector with one set port, one clear port and three read ports.
// Set wins over clear on the same bit; bit 0 can be hard-wired to zero.
module sb_regvec #(
    parameter logic ZERO_HARD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_en,
    input  logic [4:0] set_idx,
    input  logic       clr_en,
    input  logic [4:0] clr_idx,
    input  logic [4:0] rd_a_idx,
    input  logic [4:0] rd_b_idx,
    input  logic [4:0] rd_c_idx,
    output logic       rd_a,
    output logic       rd_b,
    output logic       rd_c
);

    logic [31:0] busy_r;
    logic [31:0] busy_nxt_s;
    logic [31:0] set_mask_s;
    logic [31:0] clr_mask_s;
    logic [31:0] keep_mask_s;

    // Next busy value: clear first, then set, then force the hard-zero bit.
    always_comb begin
        set_mask_s  = set_en ? (32'd1 << set_idx) : 32'd0;
        clr_mask_s  = clr_en ? (32'd1 << clr_idx) : 32'd0;
        keep_mask_s = ZERO_HARD ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
        busy_nxt_s  = ((busy_r & ~clr_mask_s) | set_mask_s) & keep_mask_s;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 32'd0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign rd_a = busy_r[rd_a_idx];
    assign rd_b = busy_r[rd_b_idx];
    assign rd_c = busy_r[rd_c_idx];

endmodule

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: tracks long-latency destinations in INT/FP busy
// vectors, stalls dependent instructions and holds one issue register.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int MAX_OUTST = MAX_OUTST_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [4:0]        rd_i,
    input  logic              rs1_fp_i,
    input  logic              rs2_fp_i,
    input  logic              rd_fp_i,
    input  logic              rd_we_i,
    input  logic              long_lat_i,
    input  logic [INST_W-1:0] inst_i,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    output logic [INST_W-1:0] issue_inst_o,
    output logic [4:0]        issue_rd_o,
    output logic              issue_rd_fp_o,
    input  logic              wb_valid_i,
    input  logic [4:0]        wb_rd_i,
    input  logic              wb_fp_i,
    input  logic              flush_i,
    output logic [3:0]        outst_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    state_t            state_r, state_nxt_s;
    logic [3:0]        outst_r;
    logic              issue_valid_r;
    logic [INST_W-1:0] issue_inst_r;
    logic [4:0]        issue_rd_r;
    logic              issue_rd_fp_r;

    logic int_rs1_s, int_rs2_s, int_rd_s;
    logic fp_rs1_s, fp_rs2_s, fp_rd_s;
    logic hazard_s, full_block_s, dec_ready_s, accept_s;
    logic inc_s, dec_s;
    logic int_set_s, fp_set_s, int_clr_s, fp_clr_s;

    // A writeback with nothing in flight is stale (e.g. crossed a reset) and is dropped.
    assign inc_s     = accept_s & long_lat_i;
    assign dec_s     = wb_valid_i & (outst_r != 4'd0);
    assign int_set_s = inc_s & rd_we_i & ~rd_fp_i;
    assign fp_set_s  = inc_s & rd_we_i & rd_fp_i;
    assign int_clr_s = dec_s & ~wb_fp_i;
    assign fp_clr_s  = dec_s & wb_fp_i;

    sb_regvec #(.ZERO_HARD(1'b1)) u_int_busy (
        .clk(i_clk), .rst(i_rst),
        .set_en(int_set_s), .set_idx(rd_i),
        .clr_en(int_clr_s), .clr_idx(wb_rd_i),
        .rd_a_idx(rs1_i), .rd_b_idx(rs2_i), .rd_c_idx(rd_i),
        .rd_a(int_rs1_s), .rd_b(int_rs2_s), .rd_c(int_rd_s)
    );

    sb_regvec #(.ZERO_HARD(1'b0)) u_fp_busy (
        .clk(i_clk), .rst(i_rst),
        .set_en(fp_set_s), .set_idx(rd_i),
        .clr_en(fp_clr_s), .clr_idx(wb_rd_i),
        .rd_a_idx(rs1_i), .rd_b_idx(rs2_i), .rd_c_idx(rd_i),
        .rd_a(fp_rs1_s), .rd_b(fp_rs2_s), .rd_c(fp_rd_s)
    );

    // Hazard and accept decision; STALL is only a bookkeeping state, so
    // readiness is re-evaluated there exactly as in RUN.
    always_comb begin
        hazard_s = dec_valid_i & (busy_sel(rs1_fp_i, int_rs1_s, fp_rs1_s) |
                                  busy_sel(rs2_fp_i, int_rs2_s, fp_rs2_s) |
                                  (rd_we_i & busy_sel(rd_fp_i, int_rd_s, fp_rd_s)));
        full_block_s = long_lat_i & (outst_r == MAX_CNT);
        dec_ready_s  = (state_r != ST_DRAIN) & ~hazard_s & (~issue_valid_r | issue_ready_i) &
                       ~full_block_s & ~flush_i;
        accept_s     = dec_valid_i & dec_ready_s;
    end

    // FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush_i) begin
                    state_nxt_s = ST_DRAIN;
                end else if (dec_valid_i && !dec_ready_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_STALL: begin
                if (flush_i) begin
                    state_nxt_s = ST_DRAIN;
                end else if (dec_ready_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            ST_DRAIN: begin
                if (!flush_i && outst_r == 4'd0) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM state and in-flight counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_RUN;
            outst_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (inc_s && !dec_s) begin
                outst_r <= outst_r + 4'd1;
            end else if (dec_s && !inc_s) begin
                outst_r <= outst_r - 4'd1;
            end else begin
                outst_r <= outst_r;
            end
        end
    end

    // Issue register: flush empties it, accept loads it, a taken issue drains it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            issue_valid_r <= 1'b0;
            issue_inst_r  <= INST_NONE;
            issue_rd_r    <= 5'd0;
            issue_rd_fp_r <= 1'b0;
        end else if (flush_i) begin
            issue_valid_r <= 1'b0;
            issue_inst_r  <= INST_NONE;
            issue_rd_r    <= 5'd0;
            issue_rd_fp_r <= 1'b0;
        end else if (accept_s) begin
            issue_valid_r <= 1'b1;
            issue_inst_r  <= inst_i;
            issue_rd_r    <= rd_i;
            issue_rd_fp_r <= rd_fp_i;
        end else if (issue_ready_i) begin
            issue_valid_r <= 1'b0;
        end else begin
            issue_valid_r <= issue_valid_r;
        end
    end

    assign dec_ready_o   = dec_ready_s;
    assign issue_valid_o = issue_valid_r;
    assign issue_inst_o  = issue_inst_r;
    assign issue_rd_o    = issue_rd_r;
    assign issue_rd_fp_o = issue_rd_fp_r;
    assign outst_o       = outst_r;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: dependency stalls, file separation,
// outstanding limit, issue backpressure, flush/drain and x0 handling.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

    logic        i_clk, i_rst;
    logic        dec_valid_i, dec_ready_o;
    logic [4:0]  rs1_i, rs2_i, rd_i;
    logic        rs1_fp_i, rs2_fp_i, rd_fp_i, rd_we_i, long_lat_i;
    logic [63:0] inst_i;
    logic        issue_valid_o, issue_ready_i;
    logic [63:0] issue_inst_o;
    logic [4:0]  issue_rd_o;
    logic        issue_rd_fp_o;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_i;
    logic        wb_fp_i, flush_i;
    logic [3:0]  outst_o;

    int total = 0;
    int bad   = 0;

    issue_scoreboard #(.MAX_OUTST(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .rs1_fp_i(rs1_fp_i), .rs2_fp_i(rs2_fp_i), .rd_fp_i(rd_fp_i),
        .rd_we_i(rd_we_i), .long_lat_i(long_lat_i), .inst_i(inst_i),
        .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
        .issue_inst_o(issue_inst_o), .issue_rd_o(issue_rd_o), .issue_rd_fp_o(issue_rd_fp_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_fp_i(wb_fp_i),
        .flush_i(flush_i), .outst_o(outst_o)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic dec(input logic [63:0] inst, input logic [4:0] r1, input logic f1,
                       input logic [4:0] r2, input logic f2, input logic [4:0] rd,
                       input logic fd, input logic we, input logic ll);
        dec_valid_i = 1'b1;
        inst_i = inst;
        rs1_i = r1; rs1_fp_i = f1;
        rs2_i = r2; rs2_fp_i = f2;
        rd_i = rd;  rd_fp_i = fd;
        rd_we_i = we; long_lat_i = ll;
    endtask

    task automatic wb(input logic [4:0] rd, input logic fp);
        wb_valid_i = 1'b1;
        wb_rd_i = rd;
        wb_fp_i = fp;
    endtask

    initial begin
        i_rst = 1'b1;
        dec_valid_i = 1'b0; inst_i = 64'd0;
        rs1_i = 5'd0; rs2_i = 5'd0; rd_i = 5'd0;
        rs1_fp_i = 1'b0; rs2_fp_i = 1'b0; rd_fp_i = 1'b0;
        rd_we_i = 1'b0; long_lat_i = 1'b0;
        issue_ready_i = 1'b1;
        wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_fp_i = 1'b0;
        flush_i = 1'b0;
        tick(); tick();
        chk("rst_outst", outst_o, 64'd0);
        chk("rst_iv", issue_valid_o, 64'd0);
        chk("rst_inst", issue_inst_o, 64'd0);
        chk("rst_rd", issue_rd_o, 64'd0);
        chk("rst_rdfp", issue_rd_fp_o, 64'd0);
        i_rst = 1'b0;
        #1 chk("rst_rdy", dec_ready_o, 64'd1);
        tick();

        // MUL x5 then dependent ADD
        dec(INST_MUL, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1);
        #1 chk("a_rdy_mul", dec_ready_o, 64'd1);
        tick();
        dec(INST_ADD, 5'd5, 1'b0, 5'd6, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
        #1 chk("a_iv", issue_valid_o, 64'd1);
        chk("a_inst", issue_inst_o, INST_MUL);
        chk("a_rd", issue_rd_o, 64'd5);
        chk("a_outst", outst_o, 64'd1);
        chk("a_rdy_haz", dec_ready_o, 64'd0);
        tick();
        chk("a_stall", dec_ready_o, 64'd0);
        chk("a_iv_drain", issue_valid_o, 64'd0);
        tick();
        wb(5'd5, 1'b0);
        #1 chk("a_nobypass", dec_ready_o, 64'd0);
        tick();
        wb_valid_i = 1'b0;
        #1 chk("a_outst0", outst_o, 64'd0);
        chk("a_rdy_after_wb", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        #1 chk("a_issue_add", issue_inst_o, INST_ADD);
        chk("a_issue_rd", issue_rd_o, 64'd7);
        chk("a_issue_iv", issue_valid_o, 64'd1);
        tick();

        // FLW f3, FSW on f3 stalls, ADD on x3 does not
        dec(INST_FLW, 5'd2, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
        #1 chk("b_rdy_flw", dec_ready_o, 64'd1);
        tick();
        dec(INST_FSW, 5'd2, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("b_fsw_stall", dec_ready_o, 64'd0);
        chk("b_rdfp", issue_rd_fp_o, 64'd1);
        chk("b_outst", outst_o, 64'd1);
        dec(INST_ADD, 5'd3, 1'b0, 5'd4, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
        #1 chk("b_int_x3_free", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        wb(5'd3, 1'b1);
        #1 chk("b_issue_add", issue_inst_o, INST_ADD);
        chk("b_issue_rdfp", issue_rd_fp_o, 64'd0);
        tick();
        wb_valid_i = 1'b0;
        #1 chk("b_outst0", outst_o, 64'd0);
        dec(INST_FSW, 5'd2, 1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("b_fsw_free", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        tick();

        // Five independent DIVs against a limit of four
        for (int i = 0; i < 4; i++) begin
            dec(INST_DIV, 5'd1, 1'b0, 5'd2, 1'b0, 5'(10 + i), 1'b0, 1'b1, 1'b1);
            #1 chk("c_rdy_div", dec_ready_o, 64'd1);
            chk("c_outst_ramp", outst_o, 64'(i));
            tick();
        end
        dec(INST_DIV, 5'd1, 1'b0, 5'd2, 1'b0, 5'd14, 1'b0, 1'b1, 1'b1);
        #1 chk("c_outst_max", outst_o, 64'd4);
        chk("c_rdy_full", dec_ready_o, 64'd0);
        tick();
        chk("c_rdy_full2", dec_ready_o, 64'd0);
        chk("c_outst_max2", outst_o, 64'd4);
        wb(5'd10, 1'b0);
        #1 chk("c_rdy_wb_cycle", dec_ready_o, 64'd0);
        tick();
        wb_valid_i = 1'b0;
        #1 chk("c_outst_3", outst_o, 64'd3);
        chk("c_rdy_fifth", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        #1 chk("c_outst_back4", outst_o, 64'd4);
        chk("c_issue_rd14", issue_rd_o, 64'd14);
        for (int j = 11; j <= 14; j++) begin
            wb(5'(j), 1'b0);
            tick();
        end
        wb_valid_i = 1'b0;
        #1 chk("c_outst_drained", outst_o, 64'd0);

        // Issue backpressure for three cycles
        issue_ready_i = 1'b0;
        dec(INST_ADD, 5'd1, 1'b0, 5'd2, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
        #1 chk("d_rdy_first", dec_ready_o, 64'd1);
        tick();
        dec(INST_SUB, 5'd1, 1'b0, 5'd2, 1'b0, 5'd20, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk("d_hold_iv", issue_valid_o, 64'd1);
            chk("d_hold_inst", issue_inst_o, INST_ADD);
            chk("d_hold_rd", issue_rd_o, 64'd9);
            chk("d_hold_rdy", dec_ready_o, 64'd0);
            tick();
        end
        issue_ready_i = 1'b1;
        #1 chk("d_rdy_release", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        #1 chk("d_issue_sub", issue_inst_o, INST_SUB);
        chk("d_issue_rd20", issue_rd_o, 64'd20);
        chk("d_issue_iv", issue_valid_o, 64'd1);
        tick();
        chk("d_no_dup", issue_valid_o, 64'd0);

        // Flush with two ops in flight
        dec(INST_MUL, 5'd1, 1'b0, 5'd2, 1'b0, 5'd6, 1'b0, 1'b1, 1'b1);
        tick();
        dec(INST_DIV, 5'd1, 1'b0, 5'd2, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1);
        tick();
        dec_valid_i = 1'b0;
        issue_ready_i = 1'b0;
        flush_i = 1'b1;
        #1 chk("e_outst2", outst_o, 64'd2);
        chk("e_iv_before", issue_valid_o, 64'd1);
        chk("e_rdy_flush", dec_ready_o, 64'd0);
        tick();
        flush_i = 1'b0;
        issue_ready_i = 1'b1;
        dec(INST_ADD, 5'd1, 1'b0, 5'd2, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0);
        #1 chk("e_iv_cleared", issue_valid_o, 64'd0);
        chk("e_inst_cleared", issue_inst_o, 64'd0);
        chk("e_rdy_drain", dec_ready_o, 64'd0);
        wb(5'd6, 1'b0);
        tick();
        chk("e_outst1", outst_o, 64'd1);
        chk("e_rdy_drain2", dec_ready_o, 64'd0);
        wb(5'd7, 1'b0);
        tick();
        wb_valid_i = 1'b0;
        #1 chk("e_outst0", outst_o, 64'd0);
        chk("e_rdy_drain3", dec_ready_o, 64'd0);
        tick();
        chk("e_rdy_run", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        #1 chk("e_issue_add", issue_inst_o, INST_ADD);
        tick();

        // Long-latency write to x0
        dec(INST_MUL, 5'd1, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        tick();
        dec(INST_ADD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
        #1 chk("f_outst1", outst_o, 64'd1);
        chk("f_x0_not_busy", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        wb(5'd0, 1'b0);
        tick();
        wb_valid_i = 1'b0;
        #1 chk("f_outst0", outst_o, 64'd0);

        // Writeback with nothing outstanding
        wb(5'd1, 1'b0);
        tick();
        wb_valid_i = 1'b0;
        #1 chk("g_no_underflow", outst_o, 64'd0);

        // Reset in the middle of tracking
        dec(INST_MUL, 5'd1, 1'b0, 5'd2, 1'b0, 5'd5, 1'b0, 1'b1, 1'b1);
        tick();
        dec_valid_i = 1'b0;
        #1 chk("h_outst1", outst_o, 64'd1);
        i_rst = 1'b1;
        #1 chk("h_rst_outst", outst_o, 64'd0);
        chk("h_rst_iv", issue_valid_o, 64'd0);
        tick();
        i_rst = 1'b0;
        dec(INST_ADD, 5'd5, 1'b0, 5'd6, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0);
        #1 chk("h_x5_released", dec_ready_o, 64'd1);
        tick();
        dec_valid_i = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
